wb_result_select: RTL and testbench

//  Write-back stage of the 5-stage CPU; consumes what the ALU-input selector's ALU produces.

---
 rtl/wb_result_select.sv | 130 +++++++++++++
 tb/tb_wb_result_select.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_result_select.sv
// Write-back stage: selects and registers the register-file write data/address/enable,
// aligns sub-word loads, and counts retired instructions for the debug display.
module wb_result_select #(
    parameter int RET_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inValid,
    input  logic             stall,
    input  logic             flush,
    input  logic [31:0]      aluResult,
    input  logic [31:0]      memData,
    input  logic [31:0]      pc,
    input  logic [4:0]       regT,
    input  logic [4:0]       regD,
    input  logic [1:0]       wbSrc,
    input  logic [1:0]       wbDst,
    input  logic [2:0]       loadType,
    input  logic             regWrite,
    output logic             regWriteEn,
    output logic [4:0]       regWriteAddr,
    output logic [31:0]      regWriteData,
    output logic [RET_W-1:0] retired
);

    localparam logic [1:0] SRC_ALU  = 2'd0;
    localparam logic [1:0] SRC_LOAD = 2'd1;
    localparam logic [1:0] SRC_PC4  = 2'd2;

    localparam logic [1:0] DST_RT   = 2'd0;
    localparam logic [1:0] DST_RD   = 2'd1;
    localparam logic [1:0] DST_RA   = 2'd2;
    localparam logic [1:0] DST_NONE = 2'd3;

    localparam logic [2:0] LD_B  = 3'd1;
    localparam logic [2:0] LD_BU = 3'd2;
    localparam logic [2:0] LD_H  = 3'd3;
    localparam logic [2:0] LD_HU = 3'd4;

    logic [7:0]       mem_byte [4];
    logic [7:0]       sel_byte;
    logic [15:0]      sel_half;
    logic [31:0]      load_data;
    logic [31:0]      pc_plus4;
    logic             capture;

    logic             vld_q, vld_d;
    logic             we_q, we_d;
    logic [4:0]       addr_q, addr_d;
    logic [31:0]      data_q, data_d;
    logic [RET_W-1:0] retired_q, retired_d;

    // Byte lanes are little-endian: lane 0 is bits [7:0].
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign mem_byte[gi] = memData[8*gi +: 8];
        end
    endgenerate

    assign sel_byte = mem_byte[aluResult[1:0]];
    assign sel_half = aluResult[1] ? memData[31:16] : memData[15:0];
    assign pc_plus4 = pc + 32'd4;
    assign capture  = !flush && !stall;

    always_comb begin
        load_data = memData;
        case (loadType)
            LD_B:    load_data = {{24{sel_byte[7]}}, sel_byte};
            LD_BU:   load_data = {24'h0, sel_byte};
            LD_H:    load_data = {{16{sel_half[15]}}, sel_half};
            LD_HU:   load_data = {16'h0, sel_half};
            default: load_data = memData;
        endcase
    end

    always_comb begin
        data_d = 32'h0;
        case (wbSrc)
            SRC_ALU:  data_d = aluResult;
            SRC_LOAD: data_d = load_data;
            SRC_PC4:  data_d = pc_plus4;
            default:  data_d = 32'h0;
        endcase
    end

    always_comb begin
        addr_d = 5'd0;
        case (wbDst)
            DST_RT:  addr_d = regT;
            DST_RD:  addr_d = regD;
            DST_RA:  addr_d = 5'd31;
            default: addr_d = 5'd0;
        endcase
    end

    // $0 is hard-wired zero, so writes to it are dropped while the address still shows 0.
    always_comb begin
        we_d      = inValid && regWrite && (wbDst != DST_NONE) && (addr_d != 5'd0);
        vld_d     = inValid;
        retired_d = retired_q;
        if (capture && inValid) begin
            retired_d = retired_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q     <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= 5'd0;
            data_q    <= 32'h0;
            retired_q <= '0;
        end else if (flush) begin
            vld_q <= 1'b0;
            we_q  <= 1'b0;
        end else if (!stall) begin
            vld_q     <= vld_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            retired_q <= retired_d;
        end
    end

    assign regWriteEn   = we_q && vld_q;
    assign regWriteAddr = addr_q;
    assign regWriteData = data_q;
    assign retired      = retired_q;

endmodule

// File: tb/tb_wb_result_select.sv
// Directed bench for the write-back stage: one task per scenario, inline checks.
module tb_wb_result_select;

    logic        clk = 1'b0;
    logic        rst;
    logic        inValid, stall, flush, regWrite;
    logic [31:0] aluResult, memData, pc;
    logic [4:0]  regT, regD;
    logic [1:0]  wbSrc, wbDst;
    logic [2:0]  loadType;
    logic        regWriteEn, regWriteEn_w;
    logic [4:0]  regWriteAddr, regWriteAddr_w;
    logic [31:0] regWriteData, regWriteData_w;
    logic [31:0] retired;
    logic [1:0]  retired_w;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    wb_result_select #(.RET_W(32)) dut (
        .clk(clk), .rst(rst), .inValid(inValid), .stall(stall), .flush(flush),
        .aluResult(aluResult), .memData(memData), .pc(pc), .regT(regT), .regD(regD),
        .wbSrc(wbSrc), .wbDst(wbDst), .loadType(loadType), .regWrite(regWrite),
        .regWriteEn(regWriteEn), .regWriteAddr(regWriteAddr),
        .regWriteData(regWriteData), .retired(retired)
    );

    // Narrow counter instance to observe wrap-around.
    wb_result_select #(.RET_W(2)) dut_w (
        .clk(clk), .rst(rst), .inValid(inValid), .stall(stall), .flush(flush),
        .aluResult(aluResult), .memData(memData), .pc(pc), .regT(regT), .regD(regD),
        .wbSrc(wbSrc), .wbDst(wbDst), .loadType(loadType), .regWrite(regWrite),
        .regWriteEn(regWriteEn_w), .regWriteAddr(regWriteAddr_w),
        .regWriteData(regWriteData_w), .retired(retired_w)
    );

    task automatic idle();
        inValid = 0; stall = 0; flush = 0; regWrite = 0;
        aluResult = 0; memData = 0; pc = 0; regT = 0; regD = 0;
        wbSrc = 0; wbDst = 3; loadType = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1;
        idle();
        repeat (3) @(posedge clk);
        #1;
        total++; if (regWriteEn !== 1'b0) begin bad++; $display("FAIL reset_en got=%0h exp=0", regWriteEn); end
        total++; if (regWriteAddr !== 5'd0) begin bad++; $display("FAIL reset_addr got=%0h exp=0", regWriteAddr); end
        total++; if (regWriteData !== 32'h0) begin bad++; $display("FAIL reset_data got=%0h exp=0", regWriteData); end
        total++; if (retired !== 32'd0) begin bad++; $display("FAIL reset_retired got=%0d exp=0", retired); end
        rst = 0;
        step();
        total++; if (regWriteEn !== 1'b0 || retired !== 32'd0) begin
            bad++; $display("FAIL post_reset_idle en=%0h ret=%0d exp en=0 ret=0", regWriteEn, retired);
        end
        $display("reset: en=%0h addr=%0d data=%h ret=%0d", regWriteEn, regWriteAddr, regWriteData, retired);
    endtask

    task automatic test_alu();
        idle();
        inValid = 1; regWrite = 1; aluResult = 32'h1234; wbSrc = 0; wbDst = 1; regD = 8;
        step();
        total++; if (regWriteEn !== 1'b1) begin bad++; $display("FAIL alu_en got=%0h exp=1", regWriteEn); end
        total++; if (regWriteAddr !== 5'd8) begin bad++; $display("FAIL alu_addr got=%0d exp=8", regWriteAddr); end
        total++; if (regWriteData !== 32'h1234) begin bad++; $display("FAIL alu_data got=%h exp=00001234", regWriteData); end
        total++; if (retired !== 32'd1) begin bad++; $display("FAIL alu_retired got=%0d exp=1", retired); end
        $display("alu: en=%0h addr=%0d data=%h ret=%0d", regWriteEn, regWriteAddr, regWriteData, retired);
    endtask

    task automatic do_load(input logic [2:0] lt, input logic [1:0] sel,
                           input logic [31:0] exp, input string name);
        idle();
        inValid = 1; regWrite = 1; memData = 32'h80FF7F01; wbSrc = 1; wbDst = 0; regT = 5;
        loadType = lt; aluResult = {30'h100, sel};
        step();
        total++; if (regWriteData !== exp) begin
            bad++; $display("FAIL %s got=%h exp=%h", name, regWriteData, exp);
        end
        $display("load %s sel=%0d: data=%h", name, sel, regWriteData);
    endtask

    task automatic test_loads();
        do_load(3'd1, 2'd3, 32'hFFFFFF80, "lb_sel3");
        do_load(3'd2, 2'd1, 32'h0000007F, "lbu_sel1");
        do_load(3'd3, 2'd2, 32'hFFFF80FF, "lh_sel2");
        do_load(3'd4, 2'd0, 32'h00007F01, "lhu_sel0");
        do_load(3'd0, 2'd2, 32'h80FF7F01, "lw");
        do_load(3'd3, 2'd3, 32'hFFFF80FF, "lh_misaligned");
        do_load(3'd7, 2'd1, 32'h80FF7F01, "ld_type7_as_lw");
        total++; if (regWriteEn !== 1'b1 || regWriteAddr !== 5'd5 || retired !== 32'd8) begin
            bad++; $display("FAIL load_ctrl en=%0h addr=%0d ret=%0d exp en=1 addr=5 ret=8",
                            regWriteEn, regWriteAddr, retired);
        end
    endtask

    task automatic test_jal();
        idle();
        inValid = 1; regWrite = 1; wbSrc = 2; wbDst = 2; pc = 32'h00003000;
        step();
        total++; if (regWriteAddr !== 5'd31 || regWriteData !== 32'h00003004 || regWriteEn !== 1'b1) begin
            bad++; $display("FAIL jal en=%0h addr=%0d data=%h exp en=1 addr=31 data=00003004",
                            regWriteEn, regWriteAddr, regWriteData);
        end
        $display("jal: addr=%0d data=%h", regWriteAddr, regWriteData);
        pc = 32'hFFFFFFFC;
        step();
        total++; if (regWriteData !== 32'h0) begin bad++; $display("FAIL jal_wrap got=%h exp=00000000", regWriteData); end
        total++; if (retired !== 32'd10) begin bad++; $display("FAIL jal_retired got=%0d exp=10", retired); end
        $display("jal wrap: data=%h ret=%0d", regWriteData, retired);
    endtask

    task automatic test_dst_guard();
        idle();
        inValid = 1; regWrite = 1; wbSrc = 0; wbDst = 0; regT = 0; aluResult = 32'hDEAD;
        step();
        total++; if (regWriteEn !== 1'b0 || regWriteAddr !== 5'd0) begin
            bad++; $display("FAIL zero_guard en=%0h addr=%0d exp en=0 addr=0", regWriteEn, regWriteAddr);
        end
        total++; if (retired !== 32'd11) begin bad++; $display("FAIL zero_retired got=%0d exp=11", retired); end
        $display("zero guard: en=%0h ret=%0d", regWriteEn, retired);
        wbDst = 3; regT = 4;
        step();
        total++; if (regWriteEn !== 1'b0) begin bad++; $display("FAIL nowrite_en got=%0h exp=0", regWriteEn); end
        wbDst = 1; regD = 9; wbSrc = 3;
        step();
        total++; if (regWriteEn !== 1'b1 || regWriteData !== 32'h0 || regWriteAddr !== 5'd9) begin
            bad++; $display("FAIL src_zero en=%0h addr=%0d data=%h exp en=1 addr=9 data=0",
                            regWriteEn, regWriteAddr, regWriteData);
        end
        regWrite = 0;
        step();
        total++; if (regWriteEn !== 1'b0 || retired !== 32'd14) begin
            bad++; $display("FAIL no_regwrite en=%0h ret=%0d exp en=0 ret=14", regWriteEn, retired);
        end
        $display("dst: en=%0h addr=%0d ret=%0d", regWriteEn, regWriteAddr, retired);
    endtask

    task automatic test_stall_flush();
        idle();
        inValid = 1; regWrite = 1; wbSrc = 0; wbDst = 1; regD = 7; aluResult = 32'hAAAA;
        step();
        stall = 1; aluResult = 32'h5555; regD = 3;
        for (int i = 0; i < 2; i++) begin
            step();
            total++; if (regWriteData !== 32'hAAAA || regWriteAddr !== 5'd7 ||
                         regWriteEn !== 1'b1 || retired !== 32'd15) begin
                bad++; $display("FAIL stall_hold%0d en=%0h addr=%0d data=%h ret=%0d exp en=1 addr=7 data=0000aaaa ret=15",
                                i, regWriteEn, regWriteAddr, regWriteData, retired);
            end
            $display("stall %0d: addr=%0d data=%h ret=%0d", i, regWriteAddr, regWriteData, retired);
        end
        stall = 0;
        step();
        total++; if (regWriteData !== 32'h5555 || regWriteAddr !== 5'd3 || retired !== 32'd16) begin
            bad++; $display("FAIL stall_release addr=%0d data=%h ret=%0d exp addr=3 data=00005555 ret=16",
                            regWriteAddr, regWriteData, retired);
        end
        stall = 1; flush = 1;
        step();
        total++; if (regWriteEn !== 1'b0 || retired !== 32'd16) begin
            bad++; $display("FAIL stall_flush en=%0h ret=%0d exp en=0 ret=16", regWriteEn, retired);
        end
        $display("stall+flush: en=%0h ret=%0d", regWriteEn, retired);
        stall = 0; flush = 0;
        step();
        total++; if (regWriteEn !== 1'b1 || retired !== 32'd17) begin
            bad++; $display("FAIL after_flush en=%0h ret=%0d exp en=1 ret=17", regWriteEn, retired);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] vals [3];
        vals[0] = 32'h11111111; vals[1] = 32'h22222222; vals[2] = 32'h33333333;
        idle();
        inValid = 1; regWrite = 1; wbSrc = 0; wbDst = 1;
        for (int i = 0; i < 3; i++) begin
            aluResult = vals[i]; regD = 5'(10 + i);
            step();
            total++; if (regWriteData !== vals[i] || regWriteAddr !== 5'(10 + i) ||
                         retired !== 32'(18 + i)) begin
                bad++; $display("FAIL b2b%0d addr=%0d data=%h ret=%0d exp addr=%0d data=%h ret=%0d",
                                i, regWriteAddr, regWriteData, retired, 10 + i, vals[i], 18 + i);
            end
            $display("b2b %0d: addr=%0d data=%h ret=%0d", i, regWriteAddr, regWriteData, retired);
        end
        // 20 retirements so far; a 2-bit counter shows 20 mod 4.
        total++; if (retired_w !== 2'd0) begin bad++; $display("FAIL ret_wrap got=%0d exp=0", retired_w); end
        inValid = 0;
        step();
        total++; if (retired_w !== 2'd0 || regWriteEn !== 1'b0) begin
            bad++; $display("FAIL idle_after_b2b ret_w=%0d en=%0h exp ret_w=0 en=0", retired_w, regWriteEn);
        end
        inValid = 1;
        step();
        total++; if (retired_w !== 2'd1 || retired !== 32'd21) begin
            bad++; $display("FAIL ret_wrap_next ret_w=%0d ret=%0d exp ret_w=1 ret=21", retired_w, retired);
        end
    endtask

    task automatic test_reset_mid();
        idle();
        inValid = 1; regWrite = 1; wbSrc = 0; wbDst = 1; regD = 12; aluResult = 32'hBEEF;
        step();
        #2 rst = 1;
        #1;
        total++; if (regWriteEn !== 1'b0 || regWriteData !== 32'h0 || retired !== 32'd0) begin
            bad++; $display("FAIL mid_reset en=%0h data=%h ret=%0d exp all 0", regWriteEn, regWriteData, retired);
        end
        #1 rst = 0;
        idle();
        step();
        total++; if (regWriteEn !== 1'b0 || regWriteAddr !== 5'd0) begin
            bad++; $display("FAIL post_mid_reset en=%0h addr=%0d exp en=0 addr=0", regWriteEn, regWriteAddr);
        end
        $display("mid reset: en=%0h ret=%0d", regWriteEn, retired);
    endtask

    initial begin
        rst = 1;
        idle();
        test_reset();
        test_alu();
        test_loads();
        test_jal();
        test_dst_guard();
        test_stall_flush();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
